// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 4-channel round-robin arbiter slice:
//   NUM_CH      number of requesters
//   CH_W        width of a channel index / priority pointer
//   arb_state_e FSM state encoding (IDLE, GRANT, GAP)
//   ch_onehot   helper turning a channel index into a one-hot grant vector
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter_4ch_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4ch_if
// Request/grant bundle between the clients and the round-robin arbiter.
//   req      client -> arbiter, one level request per channel
//   gnt      arbiter -> client, one-hot grant (0 when nobody owns the resource)
//   gnt_id   arbiter -> client, encoded owner index (meaningful while busy)
//   busy     arbiter -> client, resource currently owned
//   timeout  arbiter -> client, one-cycle pulse on forced release
// Modports:
//   master   client side (drives req)
//   slave    arbiter side (drives grant outputs)
// ---------------------------------------------------------------------------
interface rr_arbiter_4ch_if;
    import arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_id;
    logic              busy;
    logic              timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_pointer.sv
// ---------------------------------------------------------------------------
// rr_pointer
// Next-priority pointer for the round-robin arbiter: a CH_W-bit register that
// only changes when loaded. The loaded value is computed modulo NUM_CH by the
// caller, so the natural CH_W-bit wrap (3 -> 0) is all that is needed here.
// Ports:
//   clk       clock, rising edge
//   rst       reset, asynchronous, active-low; pointer returns to 0
//   load      synchronous load enable
//   load_val  value captured when load=1
//   ptr       current pointer value
// ---------------------------------------------------------------------------
module rr_pointer
    import arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CH_W-1:0] load_val,
    output logic [CH_W-1:0] ptr
);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rr_arbiter_4ch.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4ch
// Round-robin arbiter sharing one resource among four requesters. An owner
// keeps the grant while it holds its request, up to MAX_HOLD cycles, after
// which the grant is forcibly released with a one-cycle timeout pulse. Every
// release is followed by a one-cycle GAP (mux turnaround) and an IDLE cycle in
// which the next owner is chosen, so consecutive grants are separated by at
// least two cycles with gnt=0.
// Parameters:
//   MAX_HOLD  maximum grant tenure in cycles (2..255)
//   HOLD_W    hold counter width; 2**HOLD_W must exceed MAX_HOLD
// Ports:
//   clk       clock, rising edge
//   rst       reset, asynchronous, active-low
//   bus       rr_arbiter_4ch_if.slave: req in; gnt, gnt_id, busy, timeout out
// ---------------------------------------------------------------------------
module rr_arbiter_4ch
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_arbiter_4ch_if.slave    bus
);

    // ---------------------------------------------------------------- state
    arb_state_e        state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [NUM_CH-1:0] gnt_q,     gnt_d;
    logic [CH_W-1:0]   gnt_id_q,  gnt_id_d;
    logic              timeout_q, timeout_d;

    // Last hold count before a forced release; the owner has then been
    // granted for exactly MAX_HOLD cycles.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // ---------------------------------------------------------- pointer
    logic [CH_W-1:0] ptr;
    logic            ptr_load;
    logic [CH_W-1:0] ptr_load_val;

    rr_pointer u_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (ptr_load),
        .load_val (ptr_load_val),
        .ptr      (ptr)
    );

    // ----------------------------------------------------- priority scan
    // Rotate the request vector so that position 0 is the channel the pointer
    // names; the first set bit of the rotated vector is then the round-robin
    // winner, and adding the pointer back gives its absolute index.
    logic [NUM_CH-1:0] req_rot;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
            logic [CH_W-1:0] src_idx;
            assign src_idx     = ptr + CH_W'(gi);
            assign req_rot[gi] = bus.req[src_idx];
        end
    endgenerate

    logic            pick_valid;
    logic [CH_W-1:0] pick_off;
    logic [CH_W-1:0] pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_off   = '0;
        // Walk from the highest offset down so the lowest set offset wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_valid = 1'b1;
                pick_off   = CH_W'(i);
            end
        end
        pick_idx = ptr + pick_off;
    end

    // -------------------------------------------------- next-state logic
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        gnt_d        = gnt_q;
        gnt_id_d     = gnt_id_q;
        timeout_d    = 1'b0;
        ptr_load     = 1'b0;
        ptr_load_val = pick_idx + CH_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_GRANT;
                    gnt_d    = ch_onehot(pick_idx);
                    gnt_id_d = pick_idx;
                    hold_d   = '0;
                    // The pointer moves only when a grant is issued, so a
                    // channel that was timed out goes to the back of the line.
                    ptr_load = 1'b1;
                end
            end

            ST_GRANT: begin
                // Only the owner's request matters here; other channels wait.
                // A drop on the final cycle counts as a normal release.
                if (!bus.req[gnt_id_q]) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // --------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    // ----------------------------------------------------------- outputs
    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_4ch
// Self-checking bench for rr_arbiter_4ch. A behavioural model tracks the
// current owner, how many cycles it has held the resource, whether a
// turnaround cycle is pending and the round-robin start channel, and predicts
// gnt/busy/gnt_id/timeout for every cycle.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_4ch;

    localparam int MAX_HOLD = 8;
    localparam int HOLD_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_4ch_if bus ();

    rr_arbiter_4ch #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------ model
    int m_owner;     // -1 when nobody owns the resource
    int m_tenure;    // cycles the current owner has been granted so far
    bit m_turn;      // release happened; one turnaround cycle before arbitration
    bit m_to;        // forced release seen on the last edge
    int m_start;     // channel examined first at the next arbitration

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_turn   = 1'b0;
        m_to     = 1'b0;
        m_start  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_turn  = 1'b1;
            end else if (m_tenure == MAX_HOLD) begin
                m_owner = -1;
                m_turn  = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_tenure++;
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_start + i) % 4;
                if (r[c] && m_owner < 0) begin
                    m_owner  = c;
                    m_tenure = 1;
                    m_start  = (c + 1) % 4;
                end
            end
        end
    endtask

    // {gnt, busy, timeout, gnt_id (0 when idle)}
    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        logic [1:0] id;
        g  = 4'b0000;
        id = 2'b00;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id         = 2'(m_owner);
        end
        return {g, (m_owner >= 0), m_to, id};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.gnt, bus.busy, bus.timeout, (bus.busy ? bus.gnt_id : 2'b00)};
    endfunction

    // Apply one request pattern across one rising edge; returns at the
    // following falling edge, where outputs are stable.
    task automatic tick(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        $display("t=%0t req=%b gnt=%b id=%0d busy=%b to=%b",
                 $time, r, bus.gnt, bus.gnt_id, bus.busy, bus.timeout);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        bus.req = 4'b0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        logic [7:0] obs;
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        obs = dut_vec();
        n_vec++;
        if (obs !== model_vec()) begin
            n_err++;
            $display("FAIL reset_state got=%b want=%b", obs, model_vec());
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(4'b0010);
            obs = dut_vec();
            n_vec++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL midrst_pre got=%b want=%b", obs, model_vec());
            end
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        obs = dut_vec();
        n_vec++;
        if (obs !== model_vec()) begin
            n_err++;
            $display("FAIL midrst_async got=%b want=%b", obs, model_vec());
        end
        @(negedge clk);
        rst = 1'b1;
        tick(4'b0010);
        obs = dut_vec();
        n_vec++;
        if (obs !== model_vec() || bus.gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL midrst_regrant got=%b want=%b", obs, model_vec());
        end
        tick(4'b0000);
    endtask

    task automatic test_all_req();
        logic [7:0] obs;
        int starts[$];
        int n_to;
        int run;
        bit prev_busy;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        n_to      = 0;
        run       = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 45; c++) begin
            tick(4'b1111);
            obs = dut_vec();
            n_vec++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL allreq_cyc%0d got=%b want=%b", c, obs, model_vec());
            end
            if (bus.busy && !prev_busy) starts.push_back(int'(bus.gnt_id));
            if (bus.busy) run++;
            if (!bus.busy && prev_busy) begin
                n_vec++;
                if (run != MAX_HOLD) begin
                    n_err++;
                    $display("FAIL allreq_tenure got=%0d want=%0d", run, MAX_HOLD);
                end
                run = 0;
            end
            if (bus.timeout) n_to++;
            prev_busy = bus.busy;
        end
        n_vec++;
        if (starts.size() != 5) begin
            n_err++;
            $display("FAIL allreq_ngrants got=%0d want=5", starts.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (starts[i] != exp_order[i]) begin
                    n_err++;
                    $display("FAIL allreq_order%0d got=%0d want=%0d", i, starts[i], exp_order[i]);
                end
            end
        end
        n_vec++;
        if (n_to != 4) begin
            n_err++;
            $display("FAIL allreq_timeouts got=%0d want=4", n_to);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] obs;
        int starts[$];
        bit prev_busy;
        do_reset();
        // Serve channel 2 briefly so the next search starts at channel 3.
        tick(4'b0100);
        tick(4'b0000);
        tick(4'b0000);
        prev_busy = bus.busy;
        for (int c = 0; c < 14; c++) begin
            tick(4'b1001);
            obs = dut_vec();
            n_vec++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL wrap_cyc%0d got=%b want=%b", c, obs, model_vec());
            end
            if (bus.busy && !prev_busy) starts.push_back(int'(bus.gnt_id));
            prev_busy = bus.busy;
        end
        n_vec++;
        if (starts.size() < 2 || starts[0] != 3 || starts[1] != 0) begin
            n_err++;
            $display("FAIL wrap_order got=%p want=3,0", starts);
        end
    endtask

    task automatic test_short_release();
        logic [7:0] obs;
        int held;
        int n_to;
        logic [3:0] pat[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        do_reset();
        held = 0;
        n_to = 0;
        for (int c = 0; c < 6; c++) begin
            tick(pat[c]);
            obs = dut_vec();
            n_vec++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL short_cyc%0d got=%b want=%b", c, obs, model_vec());
            end
            if (bus.gnt === 4'b0100) held++;
            if (bus.timeout) n_to++;
        end
        n_vec++;
        if (held != 3 || n_to != 0) begin
            n_err++;
            $display("FAIL short_summary held=%0d to=%0d want held=3 to=0", held, n_to);
        end
    endtask

    task automatic test_drop_at_limit();
        logic [7:0] obs;
        int guard;
        do_reset();
        tick(4'b0001);
        guard = 0;
        while (m_tenure < MAX_HOLD && guard < 20) begin
            tick(4'b0001);
            guard++;
        end
        n_vec++;
        if (guard >= 20 || bus.gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL droplim_setup gnt=%b guard=%0d want gnt=0001", bus.gnt, guard);
        end
        tick(4'b0000);
        obs = dut_vec();
        n_vec++;
        if (obs !== model_vec() || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL droplim_release got=%b want=%b", obs, model_vec());
        end
        tick(4'b0000);
    endtask

    task automatic test_single();
        logic [7:0] obs;
        int run_hi;
        int run_lo;
        bit prev_busy;
        do_reset();
        run_hi    = 0;
        run_lo    = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 41; c++) begin
            tick(4'b0001);
            obs = dut_vec();
            n_vec++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL single_cyc%0d got=%b want=%b", c, obs, model_vec());
            end
            if (bus.busy && bus.gnt_id !== 2'd0) begin
                n_err++;
                $display("FAIL single_id got=%0d want=0", bus.gnt_id);
            end
            if (bus.busy) begin
                if (!prev_busy && c > 0) begin
                    n_vec++;
                    if (run_lo != 2) begin
                        n_err++;
                        $display("FAIL single_gap got=%0d want=2", run_lo);
                    end
                end
                if (!prev_busy) run_hi = 0;
                run_hi++;
            end else begin
                if (prev_busy) begin
                    n_vec++;
                    if (run_hi != MAX_HOLD) begin
                        n_err++;
                        $display("FAIL single_run got=%0d want=%0d", run_hi, MAX_HOLD);
                    end
                    run_lo = 0;
                end
                run_lo++;
            end
            prev_busy = bus.busy;
        end
    endtask

    task automatic test_random();
        logic [7:0] obs;
        logic [3:0] r;
        do_reset();
        r = 4'($urandom);
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 4) == 0) r = 4'($urandom);
            tick(r);
            obs = dut_vec();
            n_vec++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL random_cyc%0d got=%b want=%b", c, obs, model_vec());
            end
            n_vec++;
            if (!$onehot0(bus.gnt) || (bus.busy !== (|bus.gnt)) ||
                (bus.busy && bus.gnt !== (4'b0001 << bus.gnt_id))) begin
                n_err++;
                $display("FAIL random_invariant gnt=%b id=%0d busy=%b", bus.gnt, bus.gnt_id, bus.busy);
            end
        end
    endtask

    initial begin
        bus.req = 4'b0000;
        model_reset();
        @(negedge clk);
        test_reset();
        test_reset_mid_grant();
        test_all_req();
        test_wrap();
        test_short_release();
        test_drop_at_limit();
        test_single();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
